// File: rtl/m_axis_rc_adapt_x4.sv
// RC-path adapter for the UltraScale+ x4 PHY: rebuilds RC descriptors into 3DW completion headers (128-bit).
// Optional feature: define RC_ADAPT_ERR_CNT_EN to add the rc_err_cnt saturating error-packet counter.
module m_axis_rc_adapt_x4 #(
    parameter int DATA_WIDTH     = 128,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int RC_TUSER_WIDTH = 75
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [DATA_WIDTH-1:0]     m_axis_rc_tdata,
    input  logic [3:0]                m_axis_rc_tkeep,
    input  logic                      m_axis_rc_tlast,
    input  logic [RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
    input  logic                      m_axis_rc_tvalid,
    output logic [21:0]               m_axis_rc_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_rc_tdata_a,
    output logic [KEEP_WIDTH-1:0]     m_axis_rc_tkeep_a,
    output logic                      m_axis_rc_tlast_a,
    output logic [3:0]                m_axis_rc_tuser_a,
    output logic                      m_axis_rc_tvalid_a,
    input  logic                      m_axis_rc_tready_a,
    output logic                      rc_err_vld,
    output logic [3:0]                rc_err_code
`ifdef RC_ADAPT_ERR_CNT_EN
    ,
    output logic [15:0]               rc_err_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [127:0] buf_data_q [2];
    logic [127:0] buf_data_d [2];
    logic [3:0]   buf_keep_q [2];
    logic [3:0]   buf_keep_d [2];
    logic [1:0]   buf_last_q, buf_last_d;
    logic [1:0]   buf_disc_q, buf_disc_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         tready_q, tready_d;

    logic [127:0] tdata_a_q, tdata_a_d;
    logic [15:0]  tkeep_a_q, tkeep_a_d;
    logic         tlast_a_q, tlast_a_d;
    logic [3:0]   tuser_a_q, tuser_a_d;
    logic         tvalid_a_q, tvalid_a_d;
    logic         err_vld_q, err_vld_d;
    logic [3:0]   err_code_q, err_code_d;
    logic         disc_sticky_q, disc_sticky_d;
    logic         err_sticky_q, err_sticky_d;
`ifdef RC_ADAPT_ERR_CNT_EN
    logic [15:0]  err_cnt_q, err_cnt_d;
`endif

    logic         push_s, pop_s, out_ready_s, pkt_bad_s;
    logic [127:0] head_data_s;
    logic [3:0]   head_keep_s;
    logic         head_last_s, head_disc_s;
    logic [127:0] hdr_s;
    logic [15:0]  body_keep_s;
    logic         unused_tuser_s;

    // Descriptor fields of the beat at the head of the skid buffer.
    logic [11:0] lower_addr_s;
    logic [3:0]  desc_err_s;
    logic [12:0] byte_cnt_s;
    logic        locked_s;
    logic [10:0] dw_cnt_s;
    logic [2:0]  status_s;
    logic        poisoned_s;
    logic [15:0] req_id_s;
    logic [7:0]  tag_s;
    logic [15:0] cpl_id_s;
    logic [2:0]  tc_s;
    logic [2:0]  attr_s;

    assign head_data_s  = buf_data_q[rd_ptr_q];
    assign head_keep_s  = buf_keep_q[rd_ptr_q];
    assign head_last_s  = buf_last_q[rd_ptr_q];
    assign head_disc_s  = buf_disc_q[rd_ptr_q];

    assign lower_addr_s = head_data_s[11:0];
    assign desc_err_s   = head_data_s[15:12];
    assign byte_cnt_s   = head_data_s[28:16];
    assign locked_s     = head_data_s[29];
    assign dw_cnt_s     = head_data_s[42:32];
    assign status_s     = head_data_s[45:43];
    assign poisoned_s   = head_data_s[46];
    assign req_id_s     = head_data_s[63:48];
    assign tag_s        = head_data_s[71:64];
    assign cpl_id_s     = head_data_s[87:72];
    assign tc_s         = head_data_s[91:89];
    assign attr_s       = head_data_s[94:92];

    // Byte-count bit 12 is dropped; a 1024-DW completion wraps to length 0.
    assign hdr_s = {head_data_s[127:96],
                    req_id_s, tag_s, 1'b0, lower_addr_s[6:0],
                    cpl_id_s, status_s, 1'b0, byte_cnt_s[11:0],
                    (dw_cnt_s != 11'd0) ? 3'b010 : 3'b000,
                    locked_s ? 5'b01011 : 5'b01010,
                    1'b0, tc_s, 4'b0000, 1'b0, poisoned_s, attr_s[1:0], 2'b00, dw_cnt_s[9:0]};

    assign body_keep_s = {{4{head_keep_s[3]}}, {4{head_keep_s[2]}},
                          {4{head_keep_s[1]}}, {4{head_keep_s[0]}}};

    assign unused_tuser_s = ^{m_axis_rc_tuser[RC_TUSER_WIDTH-1:43], m_axis_rc_tuser[41:0]};

    // Next-state logic: skid buffer bookkeeping, header rebuild and output stage.
    always_comb begin
        push_s        = m_axis_rc_tvalid & tready_q;
        out_ready_s   = ~tvalid_a_q | m_axis_rc_tready_a;
        pop_s         = (count_q != 2'd0) & out_ready_s;
        pkt_bad_s     = 1'b0;

        buf_data_d    = buf_data_q;
        buf_keep_d    = buf_keep_q;
        buf_last_d    = buf_last_q;
        buf_disc_d    = buf_disc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        state_d       = state_q;
        tdata_a_d     = tdata_a_q;
        tkeep_a_d     = tkeep_a_q;
        tlast_a_d     = tlast_a_q;
        tuser_a_d     = tuser_a_q;
        tvalid_a_d    = tvalid_a_q;
        err_vld_d     = 1'b0;
        err_code_d    = err_code_q;
        disc_sticky_d = disc_sticky_q;
        err_sticky_d  = err_sticky_q;

        if (push_s) begin
            buf_data_d[wr_ptr_q] = m_axis_rc_tdata;
            buf_keep_d[wr_ptr_q] = m_axis_rc_tkeep;
            buf_last_d[wr_ptr_q] = m_axis_rc_tlast;
            buf_disc_d[wr_ptr_q] = m_axis_rc_tuser[42];
            wr_ptr_d             = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};
        // Ready is registered from the next occupancy so it never depends on tready_a within a cycle.
        tready_d = (count_d != 2'd2);

        if (pop_s) begin
            rd_ptr_d   = ~rd_ptr_q;
            tvalid_a_d = 1'b1;
            tlast_a_d  = head_last_s;
            state_d    = head_last_s ? ST_SOP : ST_BODY;
            case (state_q)
                ST_SOP: begin
                    tdata_a_d     = hdr_s;
                    tkeep_a_d     = (dw_cnt_s != 11'd0) ? 16'hFFFF : 16'h0FFF;
                    tuser_a_d     = {2'b00, head_last_s & head_disc_s, 1'b1};
                    err_vld_d     = (desc_err_s != 4'd0);
                    err_code_d    = (desc_err_s != 4'd0) ? desc_err_s : err_code_q;
                    disc_sticky_d = ~head_last_s & head_disc_s;
                    err_sticky_d  = ~head_last_s & (desc_err_s != 4'd0);
                    pkt_bad_s     = head_disc_s | (desc_err_s != 4'd0);
                end
                ST_BODY: begin
                    tdata_a_d     = head_data_s;
                    tkeep_a_d     = body_keep_s;
                    tuser_a_d     = {2'b00, head_last_s & (disc_sticky_q | head_disc_s), 1'b0};
                    disc_sticky_d = ~head_last_s & (disc_sticky_q | head_disc_s);
                    err_sticky_d  = ~head_last_s & err_sticky_q;
                    pkt_bad_s     = disc_sticky_q | head_disc_s | err_sticky_q;
                end
                default: begin
                    state_d = ST_SOP;
                end
            endcase
        end else if (m_axis_rc_tready_a) begin
            rd_ptr_d   = rd_ptr_q;
            tvalid_a_d = 1'b0;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            tvalid_a_d = tvalid_a_q;
        end

`ifdef RC_ADAPT_ERR_CNT_EN
        if (pop_s && head_last_s && pkt_bad_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
`endif
    end

    // State registers; reset flushes the buffer and drops any partial packet.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q       <= ST_SOP;
            buf_data_q[0] <= 128'd0;
            buf_data_q[1] <= 128'd0;
            buf_keep_q[0] <= 4'd0;
            buf_keep_q[1] <= 4'd0;
            buf_last_q    <= 2'd0;
            buf_disc_q    <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            tready_q      <= 1'b0;
            tdata_a_q     <= 128'd0;
            tkeep_a_q     <= 16'd0;
            tlast_a_q     <= 1'b0;
            tuser_a_q     <= 4'd0;
            tvalid_a_q    <= 1'b0;
            err_vld_q     <= 1'b0;
            err_code_q    <= 4'd0;
            disc_sticky_q <= 1'b0;
            err_sticky_q  <= 1'b0;
`ifdef RC_ADAPT_ERR_CNT_EN
            err_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            buf_data_q    <= buf_data_d;
            buf_keep_q    <= buf_keep_d;
            buf_last_q    <= buf_last_d;
            buf_disc_q    <= buf_disc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tready_q      <= tready_d;
            tdata_a_q     <= tdata_a_d;
            tkeep_a_q     <= tkeep_a_d;
            tlast_a_q     <= tlast_a_d;
            tuser_a_q     <= tuser_a_d;
            tvalid_a_q    <= tvalid_a_d;
            err_vld_q     <= err_vld_d;
            err_code_q    <= err_code_d;
            disc_sticky_q <= disc_sticky_d;
            err_sticky_q  <= err_sticky_d;
`ifdef RC_ADAPT_ERR_CNT_EN
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end

    assign m_axis_rc_tready   = {22{tready_q}};
    assign m_axis_rc_tdata_a  = tdata_a_q;
    assign m_axis_rc_tkeep_a  = tkeep_a_q;
    assign m_axis_rc_tlast_a  = tlast_a_q;
    assign m_axis_rc_tuser_a  = tuser_a_q;
    assign m_axis_rc_tvalid_a = tvalid_a_q;
    assign rc_err_vld         = err_vld_q;
    assign rc_err_code        = err_code_q;
`ifdef RC_ADAPT_ERR_CNT_EN
    assign rc_err_cnt         = err_cnt_q;
`endif

endmodule

// File: tb/tb_m_axis_rc_adapt_x4.sv
// Directed + random bench for m_axis_rc_adapt_x4 with a beat scoreboard and an error-code queue.
module tb_m_axis_rc_adapt_x4;

    logic user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    logic         user_reset;
    logic [127:0] m_axis_rc_tdata;
    logic [3:0]   m_axis_rc_tkeep;
    logic         m_axis_rc_tlast;
    logic [74:0]  m_axis_rc_tuser;
    logic         m_axis_rc_tvalid;
    logic [21:0]  m_axis_rc_tready;
    logic [127:0] m_axis_rc_tdata_a;
    logic [15:0]  m_axis_rc_tkeep_a;
    logic         m_axis_rc_tlast_a;
    logic [3:0]   m_axis_rc_tuser_a;
    logic         m_axis_rc_tvalid_a;
    logic         m_axis_rc_tready_a = 1'b1;
    logic         rc_err_vld;
    logic [3:0]   rc_err_code;
`ifdef RC_ADAPT_ERR_CNT_EN
    logic [15:0]  rc_err_cnt;
`endif

    m_axis_rc_adapt_x4 dut (
        .user_clk           (user_clk),
        .user_reset         (user_reset),
        .m_axis_rc_tdata    (m_axis_rc_tdata),
        .m_axis_rc_tkeep    (m_axis_rc_tkeep),
        .m_axis_rc_tlast    (m_axis_rc_tlast),
        .m_axis_rc_tuser    (m_axis_rc_tuser),
        .m_axis_rc_tvalid   (m_axis_rc_tvalid),
        .m_axis_rc_tready   (m_axis_rc_tready),
        .m_axis_rc_tdata_a  (m_axis_rc_tdata_a),
        .m_axis_rc_tkeep_a  (m_axis_rc_tkeep_a),
        .m_axis_rc_tlast_a  (m_axis_rc_tlast_a),
        .m_axis_rc_tuser_a  (m_axis_rc_tuser_a),
        .m_axis_rc_tvalid_a (m_axis_rc_tvalid_a),
        .m_axis_rc_tready_a (m_axis_rc_tready_a),
        .rc_err_vld         (rc_err_vld),
        .rc_err_code        (rc_err_code)
`ifdef RC_ADAPT_ERR_CNT_EN
        ,
        .rc_err_cnt         (rc_err_cnt)
`endif
    );

    typedef struct packed {
        logic [11:0] la;
        logic [3:0]  err;
        logic [12:0] bc;
        logic        locked;
        logic [10:0] dw;
        logic [2:0]  st;
        logic        pois;
        logic [15:0] req;
        logic [7:0]  tag;
        logic [15:0] cpl;
        logic [2:0]  tc;
        logic [2:0]  attr;
    } desc_t;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic [3:0]   u;
    } beat_t;

    beat_t       sb_q[$];
    logic [3:0]  err_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_cycles = 0;
    logic        bp_en = 1'b0;
    logic        abort_mode = 1'b0;
    logic [15:0] cnt_model = 16'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t rand_desc();
        desc_t d;
        logic [31:0] r0, r1, r2;
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        d.la = r0[11:0];  d.err = r0[15:12]; d.bc = r0[28:16]; d.locked = r0[29];
        d.st = r1[2:0];   d.pois = r1[3];    d.req = r1[19:4];  d.tag = r1[27:20];
        d.tc = r1[30:28]; d.cpl = r2[15:0];  d.attr = r2[18:16]; d.dw = r2[29:19];
        return d;
    endfunction

    function automatic logic [95:0] pack_desc(input desc_t d, input logic [95:0] filler);
        logic [95:0] v;
        v = filler;
        v[11:0] = d.la;   v[15:12] = d.err; v[28:16] = d.bc;  v[29] = d.locked;
        v[42:32] = d.dw;  v[45:43] = d.st;  v[46] = d.pois;   v[63:48] = d.req;
        v[71:64] = d.tag; v[87:72] = d.cpl; v[91:89] = d.tc;  v[94:92] = d.attr;
        return v;
    endfunction

    function automatic logic [95:0] exp_hdr(input desc_t d);
        logic [31:0] w0, w1, w2;
        w0 = {(d.dw != 11'd0) ? 3'b010 : 3'b000, d.locked ? 5'b01011 : 5'b01010, 1'b0, d.tc,
              4'b0000, 1'b0, d.pois, d.attr[1:0], 2'b00, d.dw[9:0]};
        w1 = {d.cpl, d.st, 1'b0, d.bc[11:0]};
        w2 = {d.req, d.tag, 1'b0, d.la[6:0]};
        return {w2, w1, w0};
    endfunction

    // Present one beat (called #1 after a rising edge); returns #1 after the accepting edge.
    task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic l, input logic disc);
        logic acc;
        int   waits;
        acc = 1'b0; waits = 0;
        m_axis_rc_tdata = d; m_axis_rc_tkeep = k; m_axis_rc_tlast = l;
        m_axis_rc_tuser = '0; m_axis_rc_tuser[42] = disc; m_axis_rc_tvalid = 1'b1;
        while (!acc && waits <= 2000) begin
            @(negedge user_clk);
            acc = m_axis_rc_tready[0];
            @(posedge user_clk);
            #1;
            if (!acc) waits++;
        end
        stall_cycles += waits;
        if (!acc) begin
            checks++; errors++;
            $error("FAIL send_timeout observed=no_accept expected=accept");
        end
    endtask

    // Send a packet; stop_after >= 0 truncates it and records no expectations.
    task automatic send_pkt(input desc_t d, input int disc_beat, input int stop_after);
        int          rem, nbody, nb, r;
        logic        anydisc, push_exp;
        logic [31:0] p0;
        logic [3:0]  k4;
        logic [15:0] ek;
        logic [127:0] body;
        beat_t       e;
        push_exp = (stop_after < 0);
        rem   = (d.dw != 11'd0) ? int'(d.dw) - 1 : 0;
        nbody = (rem + 3) / 4;
        nb    = 1 + nbody;
        anydisc = (disc_beat >= 0) && (disc_beat < nb);
        p0 = $urandom;
        e.d = {p0, exp_hdr(d)};
        e.k = (d.dw != 11'd0) ? 16'hFFFF : 16'h0FFF;
        e.l = (nb == 1);
        e.u = {2'b00, (nb == 1) & anydisc, 1'b1};
        if (push_exp) begin
            sb_q.push_back(e);
            if (d.err != 4'd0) err_q.push_back(d.err);
            if ((anydisc || d.err != 4'd0) && cnt_model != 16'hFFFF) cnt_model++;
        end
        send_beat({p0, pack_desc(d, {$urandom, $urandom, $urandom})}, 4'hF, nb == 1, disc_beat == 0);
        for (int i = 0; i < nbody; i++) begin
            if (stop_after >= 0 && i + 1 >= stop_after) break;
            r = rem - 4 * i;
            case (r)
                1:       k4 = 4'b0001;
                2:       k4 = 4'b0011;
                3:       k4 = 4'b0111;
                default: k4 = 4'b1111;
            endcase
            for (int j = 0; j < 4; j++) ek[4*j +: 4] = {4{k4[j]}};
            body = {$urandom, $urandom, $urandom, $urandom};
            e.d = body; e.k = ek; e.l = (i == nbody - 1);
            e.u = {2'b00, (i == nbody - 1) & anydisc, 1'b0};
            if (push_exp) sb_q.push_back(e);
            send_beat(body, k4, i == nbody - 1, disc_beat == i + 1);
        end
        m_axis_rc_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(posedge user_clk);
            n++;
        end
        repeat (3) @(posedge user_clk);
        #1;
        chk(tag, sb_q.size(), 0);
    endtask

    // Downstream ready generator; also confirms upstream ready does not follow tready_a combinationally.
    always @(posedge user_clk) begin
        logic [21:0] pre;
        #1;
        pre = m_axis_rc_tready;
        m_axis_rc_tready_a = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!user_reset) chk("tready_not_comb", m_axis_rc_tready, pre);
    end

    logic         stall_prev = 1'b0;
    logic [127:0] h_d;
    logic [15:0]  h_k;
    logic         h_l;
    logic [3:0]   h_u;

    // Output monitor: stall stability, scoreboard compare, error-code compare.
    always @(negedge user_clk) begin
        beat_t e;
        if (user_reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stable_data", m_axis_rc_tdata_a, h_d);
                chk("stable_ctl", {m_axis_rc_tvalid_a, m_axis_rc_tlast_a, m_axis_rc_tuser_a, m_axis_rc_tkeep_a},
                    {1'b1, h_l, h_u, h_k});
            end
            if (m_axis_rc_tvalid_a && m_axis_rc_tready_a) begin
                if (abort_mode) begin
                    chk("abort_no_tlast", m_axis_rc_tlast_a, 1'b0);
                end else if (sb_q.size() == 0) begin
                    chk("unexpected_beat", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", m_axis_rc_tdata_a, e.d);
                    chk("beat_keep", m_axis_rc_tkeep_a, e.k);
                    chk("beat_last", m_axis_rc_tlast_a, e.l);
                    chk("beat_user", m_axis_rc_tuser_a, e.u);
                end
            end
            if (rc_err_vld && !abort_mode) begin
                if (err_q.size() == 0) chk("unexpected_err", err_q.size(), 1);
                else chk("err_code", rc_err_code, err_q.pop_front());
            end
            stall_prev = m_axis_rc_tvalid_a & ~m_axis_rc_tready_a;
            h_d = m_axis_rc_tdata_a; h_k = m_axis_rc_tkeep_a;
            h_l = m_axis_rc_tlast_a; h_u = m_axis_rc_tuser_a;
        end
    end

    initial begin
        desc_t d;
        int    db;
        user_reset = 1'b1;
        m_axis_rc_tdata = '0; m_axis_rc_tkeep = '0; m_axis_rc_tlast = 1'b0;
        m_axis_rc_tuser = '0; m_axis_rc_tvalid = 1'b0;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_tvalid_a", m_axis_rc_tvalid_a, 1'b0);
        chk("rst_tready", m_axis_rc_tready, 22'h0);
        chk("rst_last_user_err", {m_axis_rc_tlast_a, m_axis_rc_tuser_a, rc_err_vld}, 6'd0);
        @(posedge user_clk); #1;
        user_reset = 1'b0;
        @(posedge user_clk); #1;
        chk("tready_after_rst", m_axis_rc_tready, {22{1'b1}});

        // Single-beat completion: fixed fields and 2-cycle latency.
        d = '0; d.dw = 11'd1; d.bc = 13'd4; d.tag = 8'h5A;
        send_pkt(d, -1, -1);
        @(negedge user_clk);
        chk("lat_cycle1_idle", m_axis_rc_tvalid_a, 1'b0);
        @(negedge user_clk);
        chk("lat_cycle2_valid", m_axis_rc_tvalid_a, 1'b1);
        chk("tp1_dw0", m_axis_rc_tdata_a[31:0], 32'h4A000001);
        chk("tp1_tag", m_axis_rc_tdata_a[79:72], 8'h5A);
        chk("tp1_keep", m_axis_rc_tkeep_a, 16'hFFFF);
        chk("tp1_sop_last", {m_axis_rc_tuser_a[0], m_axis_rc_tlast_a}, 2'b11);
        @(posedge user_clk); #1;

        // 64-byte completion at full rate.
        d = rand_desc(); d.dw = 11'd16; d.err = 4'd0;
        stall_cycles = 0;
        send_pkt(d, -1, -1);
        chk("full_rate_no_bubble", stall_cycles, 0);
        drain("drain_64b");

        // Zero-length completion with error code 1.
        d = rand_desc(); d.dw = 11'd0; d.err = 4'h1;
        send_pkt(d, -1, -1);
        drain("drain_zero_len");
        chk("err_code_held", rc_err_code, 4'h1);

        // Discontinue on the last beat of a 3-beat packet, then a clean packet.
        d = rand_desc(); d.dw = 11'd9; d.err = 4'd0;
        send_pkt(d, 2, -1);
        d = rand_desc(); d.dw = 11'd5; d.err = 4'd0;
        send_pkt(d, -1, -1);
        drain("drain_disc");
`ifdef RC_ADAPT_ERR_CNT_EN
        chk("err_cnt_disc", rc_err_cnt, cnt_model);
`endif

        // Maximum length wraps to length field 0.
        d = rand_desc(); d.dw = 11'd1024; d.err = 4'd0;
        send_pkt(d, -1, -1);
        drain("drain_1024");

        // Reset in the middle of a 4-beat packet, then a fresh packet.
        abort_mode = 1'b1;
        d = rand_desc(); d.dw = 11'd12; d.err = 4'd0;
        send_pkt(d, -1, 2);
        user_reset = 1'b1;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        chk("abort_rst_tvalid_a", m_axis_rc_tvalid_a, 1'b0);
        chk("abort_rst_tready", m_axis_rc_tready, 22'h0);
        @(posedge user_clk); #1;
        user_reset = 1'b0;
        abort_mode = 1'b0;
        @(posedge user_clk); #1;
        d = rand_desc(); d.dw = 11'd3; d.err = 4'h2;
        send_pkt(d, -1, -1);
        drain("drain_after_abort");

        // Random traffic with 50% downstream backpressure.
        bp_en = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            d = rand_desc();
            d.dw  = 11'($urandom_range(0, 12));
            d.err = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            db    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            send_pkt(d, db, -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge user_clk); #1;
            end
        end
        bp_en = 1'b0;
        drain("drain_random");
        chk("err_q_empty", err_q.size(), 0);
`ifdef RC_ADAPT_ERR_CNT_EN
        chk("err_cnt_final", rc_err_cnt, cnt_model);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
